// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: round-robin share of the user_io SD sector channel between floppy drives A/B.
// Optional transfer/abort statistics ports under SD_DRIVE_ARBITER_STATS_EN.
module sd_drive_arbiter #(
  parameter int unsigned     TW             = 24,
  parameter logic [TW-1:0]   TIMEOUT_CYCLES = 24'd6400000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  drv_rd,
  input  logic [1:0]  drv_wr,
  input  logic [31:0] drv_lba0,
  input  logic [31:0] drv_lba1,
  input  logic [7:0]  drv_buff_din0,
  input  logic [7:0]  drv_buff_din1,
  input  logic [1:0]  img_mounted,
  output logic [1:0]  drv_busy,
  output logic [1:0]  drv_ack,
  output logic [1:0]  drv_buff_wr,
  output logic [1:0]  drv_done,
  output logic [1:0]  drv_err,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_dout_strobe,
`ifdef SD_DRIVE_ARBITER_STATS_EN
  output logic [15:0] stat_xfers0,
  output logic [15:0] stat_xfers1,
  output logic [7:0]  stat_errs,
`endif
  output logic [7:0]  sd_buff_din
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          g_q, g_d;
  logic          last_q, last_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   lba_q, lba_d;
  logic [1:0]    rd_q, rd_d;
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    busy_q, busy_d;
  logic [1:0]    dack_q, dack_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          ack_q, stb_q;
  logic [1:0]    pend;
  logic          gsel;
  logic [1:0]    oh_g, oh_sel;
  logic          in_xfer;

  assign pend    = drv_rd | drv_wr;
  assign oh_g    = g_q ? 2'b10 : 2'b01;
  assign in_xfer = (state_q == S_XFER);

  // Arbitration and request sequencing
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    gsel    = (&pend) ? ~last_q : pend[1];
    oh_sel  = gsel ? 2'b10 : 2'b01;
    unique case (state_q)
      S_IDLE: begin
        if (|pend) begin
          g_d     = gsel;
          lba_d   = gsel ? drv_lba1 : drv_lba0;
          rd_d    = drv_rd[gsel] ? oh_sel : 2'b00;
          wr_d    = drv_rd[gsel] ? 2'b00 : oh_sel;
          busy_d  = oh_sel;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_q) begin
          rd_d    = 2'b00;
          wr_d    = 2'b00;
          state_d = S_XFER;
        end else if ((cnt_q == TIMEOUT_CYCLES - 1'b1) ||
                     img_mounted[g_q]) begin
          rd_d    = 2'b00;
          wr_d    = 2'b00;
          busy_d  = 2'b00;
          err_d   = oh_g;
          state_d = S_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XFER: begin
        if (!ack_q) begin
          done_d  = oh_g;
          busy_d  = 2'b00;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = g_q;
        state_d = S_IDLE;
      end
    endcase
    dack_d = ((state_d == S_XFER) && ack_q) ? oh_g : 2'b00;
  end

  // State, handshake sync and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      lba_q   <= '0;
      rd_q    <= 2'b00;
      wr_q    <= 2'b00;
      busy_q  <= 2'b00;
      dack_q  <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      dack_q  <= dack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= sd_ack;
      stb_q   <= sd_dout_strobe;
    end
  end

  assign drv_busy    = busy_q;
  assign drv_ack     = dack_q;
  assign drv_done    = done_q;
  assign drv_err     = err_q;
  assign sd_lba      = lba_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign drv_buff_wr = (in_xfer && stb_q) ? oh_g : 2'b00;
  assign sd_buff_din = in_xfer ? (g_q ? drv_buff_din1 : drv_buff_din0) : 8'h00;

`ifdef SD_DRIVE_ARBITER_STATS_EN
  logic [15:0] x0_q, x1_q;
  logic [7:0]  e_q;

  // Saturating completion and abort counters
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x0_q <= '0;
      x1_q <= '0;
      e_q  <= '0;
    end else begin
      if (done_d[0] && (x0_q != '1)) x0_q <= x0_q + 1'b1;
      if (done_d[1] && (x1_q != '1)) x1_q <= x1_q + 1'b1;
      if ((|err_d) && (e_q != '1))   e_q  <= e_q + 1'b1;
    end
  end

  assign stat_xfers0 = x0_q;
  assign stat_xfers1 = x1_q;
  assign stat_errs   = e_q;
`endif

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// tb_sd_drive_arbiter: directed + randomized transactions against a
// transaction-level arbitration model (round-robin pick, pulse counts).
module tb_sd_drive_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  drv_rd = '0, drv_wr = '0, img_mounted = '0;
  logic [31:0] drv_lba0 = '0, drv_lba1 = '0;
  logic [7:0]  drv_buff_din0 = '0, drv_buff_din1 = '0;
  logic        sd_ack = 1'b0, sd_dout_strobe = 1'b0;
  logic [1:0]  drv_busy, drv_ack, drv_buff_wr, drv_done, drv_err;
  logic [1:0]  sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic [7:0]  sd_buff_din;
`ifdef SD_DRIVE_ARBITER_STATS_EN
  logic [15:0] stat_xfers0, stat_xfers1;
  logic [7:0]  stat_errs;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int last_g  = 1;
  int bw_cnt[2];
  int done_cnt[2];
  int err_cnt[2];

  always #5 clk_sys = ~clk_sys;

  sd_drive_arbiter #(.TW(24), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_lba0(drv_lba0), .drv_lba1(drv_lba1),
    .drv_buff_din0(drv_buff_din0), .drv_buff_din1(drv_buff_din1),
    .img_mounted(img_mounted),
    .drv_busy(drv_busy), .drv_ack(drv_ack), .drv_buff_wr(drv_buff_wr),
    .drv_done(drv_done), .drv_err(drv_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_dout_strobe(sd_dout_strobe),
`ifdef SD_DRIVE_ARBITER_STATS_EN
    .stat_xfers0(stat_xfers0), .stat_xfers1(stat_xfers1),
    .stat_errs(stat_errs),
`endif
    .sd_buff_din(sd_buff_din)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int d);
    return (d != 0) ? 2'b10 : 2'b01;
  endfunction

  // round-robin rule: tie goes to the drive not served last
  function automatic int pick(input logic [1:0] pend, input int last);
    if (pend == 2'b11) return 1 - last;
    return pend[1] ? 1 : 0;
  endfunction

  always @(negedge clk_sys) begin
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        bw_cnt[d]   += int'(drv_buff_wr[d]);
        done_cnt[d] += int'(drv_done[d]);
        err_cnt[d]  += int'(drv_err[d]);
      end
      chk("inv_rdwr", 64'($countones(sd_rd | sd_wr) <= 1), 64'd1);
      chk("inv_busy", 64'($countones(drv_busy) <= 1), 64'd1);
      chk("inv_done_err", 64'((|drv_done) && (|drv_err)), 64'd0);
    end
  end

  task automatic chk_grant(input int g, input bit rd, input logic [31:0] lba);
    chk("grant_busy", drv_busy, oh(g));
    chk("grant_rd", sd_rd, rd ? oh(g) : 2'b00);
    chk("grant_wr", sd_wr, rd ? 2'b00 : oh(g));
    chk("grant_lba", sd_lba, lba);
  endtask

  // drive d sits in REQ at entry; run ack, strobes, completion
  task automatic serve(input int d, input logic [31:0] lba, input int dly,
                       input int nstb, input bit rnd_din,
                       input logic [7:0] din);
    int w;
    int bo, bx;
    logic [7:0] v;
    bo = bw_cnt[d];
    bx = bw_cnt[1-d];
    v  = rnd_din ? 8'($urandom) : din;
    if (d != 0) begin drv_buff_din1 = v; drv_buff_din0 = ~v; end
    else        begin drv_buff_din0 = v; drv_buff_din1 = ~v; end
    #1;
    chk("req_din0", sd_buff_din, 8'h00);
    chk("req_ack0", drv_ack, 2'b00);
    repeat (dly) @(negedge clk_sys);
    sd_ack = 1'b1;
    w = 0;
    while (((sd_rd | sd_wr) != 2'b00) && w < 10) begin
      @(negedge clk_sys);
      w++;
    end
    chk("ack_lat", w, 2);
    chk("xfer_ack", drv_ack, oh(d));
    chk("lba_hold", sd_lba, lba);
    for (int i = 0; i < nstb; i++) begin
      sd_dout_strobe = 1'b1;
      img_mounted[d] = ($urandom_range(0, 3) == 0);
      if (rnd_din) v = 8'($urandom);
      if (d != 0) begin drv_buff_din1 = v; drv_buff_din0 = ~v; end
      else        begin drv_buff_din0 = v; drv_buff_din1 = ~v; end
      #1;
      chk("xfer_din", sd_buff_din, v);
      @(negedge clk_sys);
      sd_dout_strobe = 1'b0;
      if ($urandom_range(0, 1) == 1) @(negedge clk_sys);
    end
    img_mounted = 2'b00;
    repeat (2) @(negedge clk_sys);
    sd_ack = 1'b0;
    w = 0;
    while (drv_done == 2'b00 && w < 10) begin
      @(negedge clk_sys);
      w++;
    end
    chk("done_lat", w, 2);
    chk("done_val", drv_done, oh(d));
    chk("done_busy", drv_busy, 2'b00);
    chk("done_din0", sd_buff_din, 8'h00);
    drv_rd[d] = 1'b0;
    drv_wr[d] = 1'b0;
    last_g = d;
    @(negedge clk_sys);
    #1;
    chk("done_1cyc", drv_done, 2'b00);
    chk("bw_own", bw_cnt[d] - bo, nstb);
    chk("bw_other", bw_cnt[1-d] - bx, 0);
  endtask

  // mode 0 normal, 1 remount abort, 2 timeout abort
  task automatic txn(input int d, input int op, input logic [31:0] lba,
                     input int mode, input int dly, input int nstb,
                     input bit rnd_din, input logic [7:0] din);
    int g, w, dc;
    bit rd;
    @(negedge clk_sys);
    if (d != 0) drv_lba1 = lba; else drv_lba0 = lba;
    drv_rd[d] = (op != 1);
    drv_wr[d] = (op != 0);
    rd = (op != 1);
    g  = pick(drv_rd | drv_wr, last_g);
    @(negedge clk_sys);
    chk_grant(g, rd, lba);
    drv_lba0 = $urandom;
    drv_lba1 = $urandom;
    dc = done_cnt[d];
    if (mode == 0) begin
      serve(g, lba, dly, nstb, rnd_din, din);
    end else begin
      if (mode == 1) begin
        repeat (dly) @(negedge clk_sys);
        img_mounted[d] = 1'b1;
        @(negedge clk_sys);
        img_mounted = 2'b00;
      end else begin
        w = 0;
        while (drv_err == 2'b00 && w < 200) begin
          @(negedge clk_sys);
          w++;
        end
        chk("tmo_cycles", w, 100);
      end
      chk("abort_err", drv_err, oh(d));
      chk("abort_drop", {sd_rd, sd_wr, drv_busy}, 6'd0);
      drv_rd[d] = 1'b0;
      drv_wr[d] = 1'b0;
      @(negedge clk_sys);
      #1;
      chk("err_1cyc", drv_err, 2'b00);
      chk("abort_nodone", done_cnt[d] - dc, 0);
    end
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    int g;
    int dc;
    #12;
    chk("rst_outs", {drv_busy, drv_ack, drv_buff_wr, drv_done, drv_err,
                     sd_rd, sd_wr, sd_buff_din, sd_lba}, 64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // tie from reset, then re-request so a second tie follows
    drv_lba0 = 32'h0000_0A00;
    drv_lba1 = 32'h0000_0B00;
    drv_rd   = 2'b11;
    g = pick(drv_rd | drv_wr, last_g);
    @(negedge clk_sys);
    chk_grant(g, 1'b1, (g != 0) ? 32'h0B00 : 32'h0A00);
    serve(g, (g != 0) ? 32'h0B00 : 32'h0A00, 3, 4, 1'b1, 8'h00);
    drv_rd[last_g] = 1'b1;
    g = pick(drv_rd | drv_wr, last_g);
    @(negedge clk_sys);
    chk_grant(g, 1'b1, (g != 0) ? 32'h0B00 : 32'h0A00);
    serve(g, (g != 0) ? 32'h0B00 : 32'h0A00, 2, 3, 1'b1, 8'h00);
    g = pick(drv_rd | drv_wr, last_g);
    @(negedge clk_sys);
    chk_grant(g, 1'b1, (g != 0) ? 32'h0B00 : 32'h0A00);
    serve(g, (g != 0) ? 32'h0B00 : 32'h0A00, 1, 2, 1'b1, 8'h00);
    repeat (2) @(negedge clk_sys);

    txn(0, 0, 32'h0000_0123, 0, 10, 512, 1'b1, 8'h00);
    txn(1, 1, 32'h0000_0456, 0, 5, 8, 1'b0, 8'hA5);
    txn(0, 0, 32'h0000_0789, 2, 0, 0, 1'b1, 8'h00);
    txn(1, 0, 32'h0000_0ABC, 1, 7, 0, 1'b1, 8'h00);
    txn(0, 2, 32'h0000_0DEF, 0, 4, 5, 1'b1, 8'h00);

    // async reset in the middle of a transfer
    @(negedge clk_sys);
    drv_lba0  = 32'h0000_0777;
    drv_rd[0] = 1'b1;
    @(negedge clk_sys);
    chk_grant(0, 1'b1, 32'h0000_0777);
    dc = done_cnt[0] + err_cnt[0];
    sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    sd_dout_strobe = 1'b1;
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", {drv_busy, drv_ack, drv_buff_wr, drv_done, drv_err,
                      sd_rd, sd_wr, sd_buff_din, sd_lba}, 64'd0);
    drv_rd = 2'b00;
    sd_ack = 1'b0;
    sd_dout_strobe = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    last_g  = 1;
    chk("rst_nopulse", done_cnt[0] + err_cnt[0] - dc, 0);
    txn(0, 0, 32'h0000_0321, 0, 6, 6, 1'b1, 8'h00);

    for (int k = 0; k < 30; k++) begin
      int m;
      m = $urandom_range(0, 9);
      txn($urandom_range(0, 1), $urandom_range(0, 2), $urandom,
          (m < 7) ? 0 : ((m < 9) ? 1 : 2),
          $urandom_range(0, 40), $urandom_range(1, 20), 1'b1, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
